// File: rtl/ipv4_tx_arb_pkg.sv
// ipv4_tx_arb_pkg: shared constants and types for the IPv4 TX arbiter slice.
// Optional feature macro used by this slice: IPV4_TX_ARB_WATCHDOG_EN.
package ipv4_tx_arb_pkg;

    // Beat geometry defaults; only a 16-bit beat is supported today.
    localparam int DATA_W_DEF = 16;
    localparam int LEN_W_DEF  = $clog2(DATA_W_DEF / 8);

    // Largest requester count the arbiter is built for.
    localparam int MAX_N = 8;

    // Width of the post-packet idle gap counter (gap of 0..15 cycles).
    localparam int GAP_W = 4;

    // One-hot arbiter states.
    typedef enum logic [2:0] {
        IDLE = 3'b001,
        XFER = 3'b010,
        GAP  = 3'b100
    } arb_state_t;

endpackage

// File: rtl/ipv4_tx_arb_if.sv
// ipv4_tx_arb_if: bundles the N transport-side requester channels and the
// single downstream beat channel towards the IPv4 encapsulator.
// master = arbiter side, slave = requesters plus downstream consumer.
interface ipv4_tx_arb_if
    import ipv4_tx_arb_pkg::*;
#(
    parameter int N      = 2,
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF,
    parameter int IDX_W  = $clog2(N)
);

    // Requester side
    logic [N-1:0]        req_i;
    logic [N-1:0]        valid_i;
    logic [N*DATA_W-1:0] data_i;
    logic [N*LEN_W-1:0]  len_i;
    logic [N-1:0]        last_i;
    logic [N-1:0]        cancel_i;
    logic [N-1:0]        gnt_o;
    logic [N-1:0]        ready_o;

    // Downstream side
    logic                ready_i;
    logic                valid_o;
    logic [DATA_W-1:0]   data_o;
    logic [LEN_W-1:0]    len_o;
    logic                last_o;
    logic                cancel_o;
    logic [IDX_W-1:0]    src_o;

    modport master (
        input  req_i, valid_i, data_i, len_i, last_i, cancel_i, ready_i,
        output gnt_o, ready_o, valid_o, data_o, len_o, last_o, cancel_o, src_o
    );

    modport slave (
        output req_i, valid_i, data_i, len_i, last_i, cancel_i, ready_i,
        input  gnt_o, ready_o, valid_o, data_o, len_o, last_o, cancel_o, src_o
    );

endinterface

// File: rtl/ipv4_tx_arb_rr_arb.sv
// rr_arb: combinational one-hot round-robin picker. Scans upward from ptr+1,
// wrapping modulo N, and returns the first requesting index. Kept generic so
// the RX protocol demux can reuse it.
module rr_arb #(
    parameter int N     = 2,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt_onehot,
    output logic [IDX_W-1:0] gnt_idx
);

    logic [IDX_W-1:0] cand;
    logic             found;

    // Priority scan starting just after the last winner.
    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        found      = 1'b0;
        cand       = '0;
        for (int i = 1; i <= N; i++) begin
            cand = IDX_W'((int'(ptr) + i) % N);
            if (!found && req[cand]) begin
                found            = 1'b1;
                gnt_onehot[cand] = 1'b1;
                gnt_idx          = cand;
            end
        end
    end

endmodule

// File: rtl/ipv4_tx_arb.sv
// ipv4_tx_arb: packet-granular round-robin arbiter sharing the IPv4 TX
// header-insertion path among N transport requesters. A granted requester
// owns the path until its last beat or a cancel, then a GAP_CYC idle gap.
// Optional macro IPV4_TX_ARB_WATCHDOG_EN adds a stall watchdog (WD_CYC)
// and a sticky wd_err_o output.
module ipv4_tx_arb
    import ipv4_tx_arb_pkg::*;
#(
    parameter int N       = 2,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int LEN_W   = $clog2(DATA_W / 8),
    parameter int IDX_W   = $clog2(N),
`ifdef IPV4_TX_ARB_WATCHDOG_EN
    parameter int WD_CYC  = 64,
`endif
    parameter int GAP_CYC = 2
) (
    input  logic          clk,
    input  logic          nreset,
    ipv4_tx_arb_if.master bus
`ifdef IPV4_TX_ARB_WATCHDOG_EN
    ,
    output logic          wd_err_o
`endif
);

    // Pointer reset so that requester 0 wins the first round.
    localparam int PTR_RST = ((N <= MAX_N) ? N : MAX_N) - 1;

    arb_state_t       state;
    logic [N-1:0]     gnt_q;
    logic [IDX_W-1:0] src_q;
    logic [IDX_W-1:0] ptr_q;
    logic [GAP_W-1:0] gap_cnt;

    logic [N-1:0]     pick_onehot;
    logic [IDX_W-1:0] pick_idx;

    logic             owned;
    logic             sel_valid;
    logic             sel_last;
    logic             sel_cancel_in;
    logic [DATA_W-1:0] sel_data;
    logic [LEN_W-1:0] sel_len;
    logic             own_cancel;
    logic             wd_hit;
    logic             valid_int;
    logic             beat_xfer;
    logic             end_pkt;
    logic             arb_now;

    rr_arb #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_rr_arb (
        .req        (bus.req_i),
        .ptr        (ptr_q),
        .gnt_onehot (pick_onehot),
        .gnt_idx    (pick_idx)
    );

    // Select the owner's lane; constant slices keep the mux index-width clean.
    always_comb begin
        sel_valid     = 1'b0;
        sel_last      = 1'b0;
        sel_cancel_in = 1'b0;
        sel_data      = '0;
        sel_len       = '0;
        for (int k = 0; k < N; k++) begin
            if (src_q == IDX_W'(k)) begin
                sel_valid     = bus.valid_i[k];
                sel_last      = bus.last_i[k];
                sel_cancel_in = bus.cancel_i[k];
                sel_data      = bus.data_i[k*DATA_W +: DATA_W];
                sel_len       = bus.len_i[k*LEN_W +: LEN_W];
            end
        end
    end

    // Downstream view: cancel (owner or watchdog) suppresses the beat, and
    // data/len/last read as zero whenever no beat is presented.
    always_comb begin
        owned      = (state == XFER);
        own_cancel = owned & sel_cancel_in;
        valid_int  = owned & sel_valid & ~own_cancel & ~wd_hit;
        beat_xfer  = valid_int & bus.ready_i;
        end_pkt    = own_cancel | wd_hit | (beat_xfer & sel_last);
        // The arbiter fires in IDLE and on the final GAP cycle, so the idle
        // gap between packets is exactly GAP_CYC cycles of dropped grant.
        arb_now    = (state == IDLE) | ((state == GAP) & (gap_cnt == GAP_W'(1)));

        bus.valid_o  = valid_int;
        bus.data_o   = valid_int ? sel_data : '0;
        bus.len_o    = valid_int ? sel_len  : '0;
        bus.last_o   = valid_int & sel_last;
        bus.cancel_o = own_cancel | wd_hit;
        bus.gnt_o    = gnt_q;
        bus.src_o    = src_q;
        bus.ready_o  = gnt_q & {N{bus.ready_i}};
    end

    // Ownership FSM: grant, hold until last/cancel, then count out the gap.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state   <= IDLE;
            gnt_q   <= '0;
            src_q   <= '0;
            ptr_q   <= IDX_W'(PTR_RST);
            gap_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|bus.req_i) begin
                        state <= XFER;
                        gnt_q <= pick_onehot;
                        src_q <= pick_idx;
                        ptr_q <= pick_idx;
                    end
                end
                XFER: begin
                    if (end_pkt) begin
                        gnt_q <= '0;
                        if (GAP_CYC == 0) begin
                            state <= IDLE;
                        end else begin
                            state   <= GAP;
                            gap_cnt <= GAP_W'(GAP_CYC);
                        end
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt - GAP_W'(1);
                    if (arb_now) begin
                        if (|bus.req_i) begin
                            state <= XFER;
                            gnt_q <= pick_onehot;
                            src_q <= pick_idx;
                            ptr_q <= pick_idx;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt_q <= '0;
                end
            endcase
        end
    end

`ifdef IPV4_TX_ARB_WATCHDOG_EN
    localparam int WD_W = $clog2(WD_CYC + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            wd_err_q;

    assign wd_hit   = owned & ~sel_valid & (wd_cnt == WD_W'(WD_CYC - 1));
    assign wd_err_o = wd_err_q;

    // Stall watchdog: counts owner cycles without a valid beat; sticky error.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            wd_cnt   <= '0;
            wd_err_q <= 1'b0;
        end else begin
            if (!owned || beat_xfer) begin
                wd_cnt <= '0;
            end else if (!sel_valid) begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end
            if (wd_hit) begin
                wd_err_q <= 1'b1;
            end
        end
    end
`else
    assign wd_hit = 1'b0;
`endif

endmodule

// File: doc/ipv4_tx_arb.md
Name: ipv4_tx_arb

Overview:
- Packet-granular round-robin arbiter that shares the single IPv4 TX header-insertion/MAC path among N transport-layer requesters (UDP/ICMP/etc.).
- Sits between transport TX blocks and the IPv4 TX encapsulator.
- Once a requester is granted, it owns the path until its last beat or a cancel, followed by a programmable idle gap.
- Muxes data/len/last, forwards downstream backpressure, and reports the owning source index.

Parameters:
- N, 2, number of requesters (2..8).
- DATA_W, 16, beat width in bits; only 16 is supported.
- LEN_W, $clog2(DATA_W/8), valid-byte count width per beat.
- IDX_W, $clog2(N), source index width.
- GAP_CYC, 2, idle cycles enforced after each packet end (0..15).
- WD_CYC, 64, watchdog limit, used only with the optional feature.

Ports:
- clk  in  1  clock.
- nreset  in  1  synchronous, active-low reset.
- req_i  in  N  per-requester "packet pending"; level; held until granted.
- valid_i  in  N  per-requester beat valid.
- data_i  in  N*DATA_W  per-requester beat data; requester k in slice [k*DATA_W+:DATA_W].
- len_i  in  N*LEN_W  per-requester valid bytes; 0 encodes full beat.
- last_i  in  N  per-requester last beat of packet.
- cancel_i  in  N  per-requester abort of the current packet.
- gnt_o  out  N  one-hot ownership, held for the whole packet.
- ready_o  out  N  per-requester beat accept = gnt_o[k] & ready_i.
- ready_i  in  1  downstream accept.
- valid_o  out  1  muxed beat valid.
- data_o  out  DATA_W  muxed data.
- len_o  out  LEN_W  muxed len.
- last_o  out  1  muxed last.
- cancel_o  out  1  abort to downstream, single-cycle pulse.
- src_o  out  IDX_W  index of the current owner.

Behaviour:
- Reset: nreset is synchronous, active-low; clock is clk.
  - Reset values: state=IDLE, gnt_o=0, valid_o=0, last_o=0, cancel_o=0, src_o=0.
  - RR pointer resets to N-1, so requester 0 has first priority.
  - Gap counter resets to 0.
- FSM states: IDLE, XFER, GAP (one-hot).
- IDLE:
  - If |req_i, select the first set bit scanning upward from ptr+1 and wrapping mod N.
  - Register gnt_o/src_o and go to XFER. Grant is visible the cycle after req is sampled (1-cycle latency).
  - ptr updates to the granted index at the same edge.
- XFER:
  - valid_o = valid_i[src] & gnt.
  - data_o, len_o, last_o are combinationally muxed from src; they are zero when not valid.
  - A beat transfers when valid_o & ready_i.
  - Transfer with last_o set: drop gnt_o at the next edge, load the gap counter with GAP_CYC, go to GAP. If GAP_CYC=0, go directly to IDLE.
  - cancel_i[src]: cancel_o=1 in the same cycle (combinational), valid_o is forced to 0, release as for last.
  - cancel_i from non-owners is ignored.
  - If cancel and last coincide, cancel wins and that beat is not forwarded.
- GAP:
  - gnt_o=0. Counter decrements every cycle regardless of ready_i.
  - At counter==1, next state is IDLE.
  - Requests raised during GAP are arbitrated on entry to IDLE.
- Fairness: a requester that just finished has lowest priority next round. With all N requesting, service order is strictly cyclic.
- Single requester: re-granted back-to-back after GAP.
- req_i dropped while pending and before grant: no grant is issued.
- req_i dropped while owned: ignored; ownership ends only on last/cancel.
- Backpressure: ready_i=0 holds the beat; the requester must keep data stable.
- Reset mid-packet: immediate return to IDLE. No cancel_o is generated; downstream is reset in the same domain.

Optional Feature:
- Macro: IPV4_TX_ARB_WATCHDOG_EN.
- Defined:
  - A counter clears on each transferred beat and increments in XFER while valid_i[src]=0.
  - On reaching WD_CYC: cancel_o pulses for one cycle, ownership is released, go to GAP.
  - A sticky wd_err_o output port (1 bit) is added; it is cleared only by reset.
- Not defined: no counter and no wd_err_o port; an owner may stall indefinitely.

Decomposition:
- ipv4_pkg holds:
  - DATA_W/LEN_W defaults.
  - FSM state localparams.
  - MAX_N=8.
  - Gap counter width constant (4).
- One natural sub-module: rr_arb, a combinational one-hot round-robin picker with inputs req, ptr and outputs gnt_onehot, gnt_idx.
  - Reusable for the future RX protocol demux.

Test Plan:
- Reset: nreset=0 for 2 cycles, N=2 → all outputs 0.
  - Then req_i=2'b11 → gnt_o=2'b01 one cycle later, src_o=0.
- Round-robin, N=4, GAP_CYC=2: all four req_i held, each packet 3 beats, ready_i=1.
  - Grants must be ordered 0,1,2,3,0.
  - Exactly 2 idle cycles between each last_o and the next gnt_o.
- Backpressure: requester 1 sends data 16'hABCD with ready_i toggling 1,0,0,1.
  - valid_o and data_o are held stable during ready_i=0.
  - ready_o[1] mirrors ready_i.
  - The beat is counted exactly once.
- Cancel: owner 0 asserts cancel_i[0] on beat 2 together with last_i.
  - cancel_o=1 in the same cycle, valid_o=0.
  - Then GAP, then grant passes to waiting requester 1.
  - cancel_i[1] asserted while 0 owns the path → no effect.
- len passthrough: final beat of a 5-byte packet with len_i=1 → len_o=1 and last_o=1 in the same cycle; non-owner data is never visible on data_o.
- Watchdog (macro defined, WD_CYC=64): owner asserts no valid for 64 cycles → cancel_o pulse at cycle 64, wd_err_o=1 and stays 1, next requester granted after GAP.
